bcd_conv_arbiter: RTL and testbench

- Sequential, shared binary-to-BCD converter serving two requesters (e.g. score and timer paths) ahead of the 4-digit display driver.
- Round-robin arbiter grants one requester at a time and latches its binary value.
- Iterative shift-add-3 (double dabble) engine performs one bit per clock; result is delivered with a valid pulse and a per-requester ack.
- Replaces per-source combinational converters, so the display path carries one shared converter.

---
 rtl/bcd_conv_arbiter.sv | 92 +++++++++
 tb/tb_bcd_conv_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin shared binary-to-BCD converter (one double-dabble bit per clock)
module bcd_conv_arbiter #(
  parameter int BIN_W   = 14,
  parameter int DIGITS  = 4,
  parameter int MAX_VAL = 9999
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic [BIN_W-1:0]      bin0,
  input  logic                  req1,
  input  logic [BIN_W-1:0]      bin1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  out_valid,
  output logic                  out_id,
  output logic                  ovf,
  output logic                  busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam int CW = $clog2(BIN_W);
  localparam logic [BIN_W-1:0] MAXV = BIN_W'(MAX_VAL);
  localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);
  logic [1:0]          state;
  logic                ptr;
  logic [BIN_W-1:0]    lbin;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] sreg;
  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] nxt;
  logic                gnt;
  logic [BIN_W-1:0]    sel;
  logic                clamp;
  assign busy = state != IDLE;
  // round-robin pick: on a tie the requester not served last wins
  always_comb begin
    gnt   = (req0 && req1) ? ~ptr : req1;
    sel   = gnt ? bin1 : bin0;
    clamp = sel > MAXV;
  end
  // one engine step: add 3 to digits >= 5, then shift in the next input bit (msb first)
  always_comb begin
    adj = sreg;
    for (int d = 0; d < DIGITS; d++)
      adj[4*d +: 4] = (sreg[4*d +: 4] >= 4'd5) ? sreg[4*d +: 4] + 4'd3 : sreg[4*d +: 4];
    nxt    = adj << 1;
    nxt[0] = lbin[BIN_W-1];
  end
  // arbitration, iteration control and result registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b1;
      lbin      <= '0;
      cnt       <= '0;
      sreg      <= '0;
      bcd_out   <= '0;
      out_id    <= 1'b0;
      ovf       <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      out_valid <= 1'b0;
      if (state == IDLE && (req0 || req1)) begin
        state  <= SHIFT;
        ptr    <= gnt;
        out_id <= gnt;
        ovf    <= clamp;
        lbin   <= clamp ? MAXV : sel;
        sreg   <= '0;
        cnt    <= '0;
      end else if (state == SHIFT) begin
        sreg <= nxt;
        lbin <= lbin << 1;
        cnt  <= cnt + 1'b1;
        if (cnt == LAST) begin
          state     <= DONE;
          bcd_out   <= nxt;
          out_valid <= 1'b1;
          ack0      <= ~out_id;
          ack1      <= out_id;
        end
      end else if (state == DONE)
        state <= IDLE;
    end
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb_bcd_conv_arbiter: table vectors plus multi-cycle sequences, checked through a result scoreboard
module tb_bcd_conv_arbiter;
  logic clk = 0, rst_n = 0, req0 = 0, req1 = 0;
  logic [13:0] bin0 = 0, bin1 = 0;
  logic ack0, ack1, out_valid, out_id, ovf, busy;
  logic [15:0] bcd_out;
  int pass = 0, total = 0, nres = 0, nexp = 0;
  typedef struct {logic id; logic [13:0] bin; logic [15:0] bcd; logic ovf;} vec_t;
  typedef struct {logic id; logic [15:0] bcd; logic ovf;} exp_t;
  exp_t sb[$];
  vec_t tv[9];

  bcd_conv_arbiter dut (.clk(clk), .rst_n(rst_n), .req0(req0), .bin0(bin0), .req1(req1), .bin1(bin1),
    .ack0(ack0), .ack1(ack1), .bcd_out(bcd_out), .out_valid(out_valid), .out_id(out_id), .ovf(ovf), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
  endtask

  task automatic expect_res(input logic id, input logic [15:0] b, input logic o);
    exp_t x;
    x.id = id; x.bcd = b; x.ovf = o;
    sb.push_back(x);
    nexp++;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 40);
    if (!out_valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_bcd"}, bcd_out, 0);
    chk({nm, "_id"}, out_id, 0);
    chk({nm, "_ovf"}, ovf, 0);
    chk({nm, "_flags"}, {ack0, ack1, out_valid, busy}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0; #1;
    check_zero("reset");
    @(negedge clk); rst_n = 1;
  endtask

  task automatic conv(input logic id, input logic [13:0] b, input logic [15:0] e, input logic o);
    int n;
    expect_res(id, e, o);
    @(posedge clk); #1;
    if (id) begin req1 = 1; bin1 = b; end else begin req0 = 1; bin0 = b; end
    wait_valid(n);
    chk("latency", n, 16);
    chk("busy_done", busy, 1);
    req0 = 0; req1 = 0;
    @(negedge clk);
    chk("busy_idle", busy, 0);
  endtask

  // scoreboard: every result pulse is matched against the oldest expectation
  always @(negedge clk)
    if (out_valid) begin
      exp_t e;
      nres++;
      if (sb.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        e = sb.pop_front();
        chk("bcd_out", bcd_out, e.bcd);
        chk("out_id", out_id, e.id);
        chk("ovf", ovf, e.ovf);
        chk("ack0", ack0, !e.id);
        chk("ack1", ack1, e.id);
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    tv[0] = '{1'b0, 14'd1234,  16'h1234, 1'b0};
    tv[1] = '{1'b1, 14'd16383, 16'h9999, 1'b1};
    tv[2] = '{1'b1, 14'd0,     16'h0000, 1'b0};
    tv[3] = '{1'b0, 14'd9999,  16'h9999, 1'b0};
    tv[4] = '{1'b0, 14'd10000, 16'h9999, 1'b1};
    tv[5] = '{1'b1, 14'd5,     16'h0005, 1'b0};
    tv[6] = '{1'b0, 14'd8191,  16'h8191, 1'b0};
    tv[7] = '{1'b1, 14'd4095,  16'h4095, 1'b0};
    tv[8] = '{1'b0, 14'd1000,  16'h1000, 1'b0};
    repeat (2) @(posedge clk);
    #1 check_zero("por");
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 9; i++) conv(tv[i].id, tv[i].bin, tv[i].bcd, tv[i].ovf);
    // tie straight after reset: requester 0 first, requester 1 exactly 16 cycles later
    do_reset();
    expect_res(0, 16'h0001, 0);
    expect_res(1, 16'h9999, 0);
    @(posedge clk); #1;
    req0 = 1; bin0 = 1; req1 = 1; bin1 = 9999;
    wait_valid(n);
    chk("tie_first_ack0", ack0, 1);
    req0 = 0;
    wait_valid(n);
    chk("tie_spacing", n, 16);
    req1 = 0;
    // input changed mid-conversion must not affect the result
    expect_res(0, 16'h0042, 0);
    @(negedge clk); #1;
    req0 = 1; bin0 = 42;
    repeat (4) @(negedge clk);
    bin0 = 77;
    wait_valid(n);
    req0 = 0;
    // req0 held high, req1 joins during the first conversion: ids alternate
    expect_res(0, 16'h0011, 0);
    expect_res(1, 16'h0022, 0);
    expect_res(0, 16'h0011, 0);
    expect_res(1, 16'h0022, 0);
    @(negedge clk); #1;
    req0 = 1; bin0 = 11;
    repeat (3) @(negedge clk);
    req1 = 1; bin1 = 22;
    for (int k = 0; k < 4; k++) wait_valid(n);
    req0 = 0; req1 = 0;
    repeat (3) @(negedge clk);
    chk("alt_idle", busy, 0);
    // reset in SHIFT iteration 7 aborts silently; a fresh conversion follows
    @(posedge clk); #1;
    req0 = 1; bin0 = 500;
    repeat (9) @(negedge clk);
    chk("pre_abort_busy", busy, 1);
    rst_n = 0; #1;
    check_zero("abort");
    @(negedge clk);
    chk("abort_held", {ack0, out_valid, busy}, 0);
    expect_res(0, 16'h0500, 0);
    rst_n = 1;
    wait_valid(n);
    req0 = 0;
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("result_count", nres, nexp);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
